// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix writeback slice.
package matrix_pkg;

  // Elements per result vector and the width of an element index.
  localparam int VEC_LEN    = 4;
  localparam int ELEM_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } wb_state_t;

endpackage

// File: rtl/matrix_writeback_if.sv
// Result-vector stream from the controller plus the single-beat memory
// write port. "master" is the environment (controller + memory), "slave"
// is the writeback stage.
interface matrix_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  import matrix_pkg::*;

  logic                      in_valid;
  logic [VEC_LEN*DATA_W-1:0] in_data;
  logic                      in_ready;

  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ack;

  modport master (
    output in_valid, in_data, mem_ack,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, mem_ack,
    output in_ready, mem_req, mem_addr, mem_wdata
  );

endinterface

// File: rtl/matrix_writeback_fifo.sv
// Synchronous FIFO holding whole result vectors. DEPTH must be a power of
// two so the pointers wrap on their own.
module wb_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Vector storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/matrix_writeback.sv
// Writeback stage: buffers result vectors and serialises them into element
// writes at base + 4*index + element, counting retired vectors per job.
// Optional build macro MATRIX_WB_STALL_CNT_EN adds the stall_cycles counter.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no job; waits for start (FIFO still accepts vectors)
//   POP    | waits for a buffered vector and loads the holding register
//   WRITE  | presents one element per request until acked
//   FINISH | last vector retired; done is registered out of this state
module matrix_writeback
  import matrix_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [15:0]       cfg_count,
  matrix_writeback_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef MATRIX_WB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int VEC_W = VEC_LEN * DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ELEM_IDX_W-1:0] LAST_ELEM = ELEM_IDX_W'(VEC_LEN - 1);

  wb_state_t             state_q;
  logic [ADDR_W-1:0]     base_q;
  logic [15:0]           count_q;
  logic [15:0]           index_q;
  logic [ELEM_IDX_W-1:0] elem_q;
  logic [VEC_W-1:0]      hold_q;
  logic                  mem_req_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  overflow_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [VEC_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic [ADDR_W-1:0]     row_addr_d;
  logic [ELEM_IDX_W-1:0] elem_d;

  assign fifo_push = bus.in_valid && !fifo_full;
  assign fifo_pop  = (state_q == POP) && !fifo_empty;

  // Row address wraps modulo 2^ADDR_W; the index shift is truncated with it.
  assign row_addr_d = base_q + ADDR_W'({index_q, 2'b00});
  assign elem_d     = elem_q + ELEM_IDX_W'(1);

  wb_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (bus.in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Slot availability comes from registered occupancy, so a pop only frees
  // space for the following cycle.
  assign bus.in_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

  // Job sequencing, address generation and registered port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      index_q     <= '0;
      elem_q      <= '0;
      hold_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= cfg_base;
            count_q <= cfg_count;
            index_q <= '0;
            elem_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= (cfg_count == 16'd0) ? FINISH : POP;
          end
        end
        POP: begin
          if (!fifo_empty) begin
            hold_q      <= fifo_rdata;
            elem_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= row_addr_d;
            mem_wdata_q <= fifo_rdata[DATA_W-1:0];
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            if (elem_q != LAST_ELEM) begin
              elem_q      <= elem_d;
              mem_addr_q  <= row_addr_d + ADDR_W'(elem_d);
              mem_wdata_q <= hold_q[int'(elem_d)*DATA_W +: DATA_W];
            end else begin
              mem_req_q <= 1'b0;
              index_q   <= index_q + 16'd1;
              state_q   <= (index_q + 16'd1 == count_q) ? FINISH : POP;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a vector offered while every slot was taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.in_valid && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

`ifdef MATRIX_WB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles a request waits for its ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (mem_req_q && !bus.mem_ack && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_matrix_writeback.sv
// Directed bench for matrix_writeback with a job-level write model.
module tb_matrix_writeback;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [15:0]   cfg_count;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef MATRIX_WB_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  matrix_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  matrix_writeback #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_count (cfg_count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
`ifdef MATRIX_WB_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job model: the configured base/count plus the vectors the bench expects
  // to have been accepted; write k of a job goes to vector k/4, element k%4.
  logic [4*DW-1:0] vec_q[$];
  logic [AW-1:0]   m_base;
  int              m_count = 0;
  int              m_nw    = 0;
  int              m_done  = 0;
  logic [AW-1:0]   wlog_a[$];
  logic [DW-1:0]   wlog_d[$];

  int ack_mode = 0;
  int ack_cyc  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] mkvec(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int n);
    start     = 1'b1;
    cfg_base  = b;
    cfg_count = n[15:0];
    m_base    = b;
    m_count   = n;
    m_nw      = 0;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [4*DW-1:0] v, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    if (accept) vec_q.push_back(v);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      at_neg();
      if (done) seen = 1'b1;
      step();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  // Cycles from the start cycle to the cycle done is visible.
  task automatic measure_done(input string name, output int off);
    off = -1;
    for (int k = 1; k <= 60 && off < 0; k++) begin
      at_neg();
      if (done) off = k;
      step();
    end
    if (off < 0) begin
      total++;
      bad++;
      $display("FAIL %s: done not seen within 60 cycles", name);
    end
  endtask

  task automatic check_reset(input string p);
    check({p, "_in_ready"}, bus.in_ready, 1);
    check({p, "_mem_req"}, bus.mem_req, 0);
    check({p, "_mem_addr"}, bus.mem_addr, 0);
    check({p, "_mem_wdata"}, bus.mem_wdata, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_overflow"}, overflow, 0);
  endtask

  // Memory-side responder: 0 = always ack, 1 = ack one cycle in three, 2 = never.
  initial bus.mem_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    ack_cyc++;
    case (ack_mode)
      0:       bus.mem_ack = 1'b1;
      1:       bus.mem_ack = (ack_cyc % 3 == 0);
      default: bus.mem_ack = 1'b0;
    endcase
  end

  // Per-cycle comparison of the memory port and done against the model.
  logic          p_req = 1'b0;
  logic          p_ack = 1'b0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  always @(negedge clk) begin
    int              e;
    int              vi;
    logic [AW-1:0]   exp_a;
    logic [4*DW-1:0] hv;
    if (!rst_n) begin
      p_req = 1'b0;
    end else begin
      if (p_req && !p_ack) begin
        check("req_hold", bus.mem_req, 1);
        check("addr_hold", bus.mem_addr, p_addr);
        check("data_hold", bus.mem_wdata, p_data);
      end
      if (bus.mem_req) check("req_implies_busy", busy, 1);
      if (bus.mem_req && bus.mem_ack) begin
        if (m_nw >= 4 * m_count || vec_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=0x%0h data=0x%0h required none", bus.mem_addr, bus.mem_wdata);
        end else begin
          vi    = m_nw / 4;
          e     = m_nw % 4;
          exp_a = m_base + AW'(4 * vi + e);
          hv    = vec_q[0];
          check("wr_addr", bus.mem_addr, exp_a);
          check("wr_data", bus.mem_wdata, hv[e*DW +: DW]);
          if (e == 3) void'(vec_q.pop_front());
          m_nw++;
        end
        wlog_a.push_back(bus.mem_addr);
        wlog_d.push_back(bus.mem_wdata);
      end
      if (done) begin
        m_done++;
        check("done_after_all_writes", m_nw, 4 * m_count);
        check("done_busy_low", busy, 0);
      end
      p_req  = bus.mem_req;
      p_ack  = bus.mem_ack;
      p_addr = bus.mem_addr;
      p_data = bus.mem_wdata;
    end
  end

  initial begin
    int            off;
    logic [AW-1:0] exp4 [4];
    exp4 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    rst_n        = 1'b0;
    start        = 1'b0;
    cfg_base     = '0;
    cfg_count    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) step();
    at_neg();
    check_reset("rst");
    rst_n = 1'b1;
    step();

    // Single vector {4,3,2,1} pushed while waiting in POP, ack always high.
    ack_mode = 0;
    wlog_a.delete(); wlog_d.delete();
    do_start(16'h0100, 1);
    push(mkvec(32'd1), 1'b1);
    at_neg(); check("t1_pop_cycle_req", bus.mem_req, 0);
    step(); at_neg();
    check("t1_first_req", bus.mem_req, 1);
    check("t1_first_addr", bus.mem_addr, 16'h0100);
    check("t1_first_data", bus.mem_wdata, 1);
    repeat (3) step();
    at_neg();
    check("t1_last_addr", bus.mem_addr, 16'h0103);
    check("t1_last_data", bus.mem_wdata, 4);
    step(); at_neg();
    check("t1_finish_busy", busy, 1);
    check("t1_finish_done", done, 0);
    check("t1_finish_req", bus.mem_req, 0);
    step(); at_neg();
    check("t1_done_pulse", done, 1);
    check("t1_busy_fall", busy, 0);
    step(); at_neg();
    check("t1_done_clear", done, 0);
    step();
    check("t1_nwrites", wlog_a.size(), 4);
    for (int i = 0; i < wlog_a.size() && i < 4; i++) begin
      check("t1_log_addr", wlog_a[i], 16'h0100 + i);
      check("t1_log_data", wlog_d[i], i + 1);
    end

    // Three vectors, ack low two cycles out of three.
    ack_mode = 1;
    for (int j = 0; j < 3; j++) push(mkvec(32'h2000 + 4 * j), 1'b1);
    wlog_a.delete(); wlog_d.delete();
    do_start(16'h0100, 3);
    wait_done("t2_done", 400);
    check("t2_nwrites", wlog_a.size(), 12);
    for (int i = 0; i < wlog_a.size() && i < 12; i++) begin
      check("t2_log_addr", wlog_a[i], 16'h0100 + i);
      check("t2_log_data", wlog_d[i], 32'h2000 + i);
    end

    // Fill the FIFO while idle, overflow with a fifth vector.
    ack_mode = 2;
    for (int j = 0; j < 4; j++) begin
      push(mkvec(32'h3000 + 4 * j), 1'b1);
      at_neg();
      check("t3_in_ready", bus.in_ready, (j < 3) ? 1 : 0);
      check("t3_overflow_pre", overflow, 0);
      step();
    end
    push(mkvec(32'h3010), 1'b0);
    at_neg();
    check("t3_overflow_set", overflow, 1);
    check("t3_still_full", bus.in_ready, 0);
    step();
    wlog_a.delete(); wlog_d.delete();
    do_start(16'h0400, 4);
    repeat (10) step();
    at_neg();
    check("t3_stall_req", bus.mem_req, 1);
    check("t3_stall_addr", bus.mem_addr, 16'h0400);
    check("t3_stall_data", bus.mem_wdata, 32'h3000);
    step();
    ack_mode = 0;
    wait_done("t3_done", 200);
    repeat (4) step();
    check("t3_nwrites", wlog_a.size(), 16);
    if (wlog_d.size() == 16) check("t3_last_data", wlog_d[15], 32'h300F);
    check("t3_overflow_sticky", overflow, 1);

    // Address wrap at the top of the space; vector already buffered.
    for (int i = 0; i < 1; i++) push(mkvec(32'h4000), 1'b1);
    wlog_a.delete(); wlog_d.delete();
    do_start(16'hFFFE, 1);
    measure_done("t4_done", off);
    check("t4_job_time", off, 1 + 1 * 5 + 1);
    check("t4_nwrites", wlog_a.size(), 4);
    for (int i = 0; i < wlog_a.size() && i < 4; i++) check("t4_wrap_addr", wlog_a[i], exp4[i]);

    // Zero-length job.
    do_start(16'h0500, 0);
    at_neg();
    check("t5_finish_busy", busy, 1);
    check("t5_no_req", bus.mem_req, 0);
    check("t5_done_not_yet", done, 0);
    step(); at_neg();
    check("t5_done", done, 1);
    check("t5_busy_low", busy, 0);
    step(); at_neg();
    check("t5_done_clear", done, 0);
    step();

    // Reset during the second element write, then a fresh job.
    push(mkvec(32'h6000), 1'b1);
    wlog_a.delete(); wlog_d.delete();
    do_start(16'h0200, 1);
    step();
    at_neg(); check("t6_elem0_addr", bus.mem_addr, 16'h0200);
    step();
    rst_n = 1'b0;
    vec_q.delete();
    m_count = 0;
    m_nw    = 0;
    at_neg();
    check("t6_elem1_req", bus.mem_req, 1);
    check("t6_elem1_addr", bus.mem_addr, 16'h0201);
    step();
    rst_n = 1'b1;
    at_neg();
    check_reset("t6_after_rst");
    step();
    check("t6_writes_before_rst", wlog_a.size(), 1);
    wlog_a.delete(); wlog_d.delete();
    push(mkvec(32'h7000), 1'b1);
    do_start(16'h0300, 1);
    wait_done("t6_done", 100);
    check("t6_nwrites", wlog_a.size(), 4);
    for (int i = 0; i < wlog_a.size() && i < 4; i++) begin
      check("t6_log_addr", wlog_a[i], 16'h0300 + i);
      check("t6_log_data", wlog_d[i], 32'h7000 + i);
    end

    repeat (3) step();
    check("done_pulses", m_done, 6);
    check("vectors_consumed", vec_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/matrix_writeback.md
# matrix_writeback

Result writeback stage directly downstream of the matrix processor controller. It accepts one 4-element result vector per work item, each produced when the controller asserts its write enable, and buffers the vectors in a small FIFO. It serialises each vector into element writes on a single-beat req/ack memory port at base + 4·index + element. It counts completed work items against a configured total and pulses `done` when all have retired.

## Interface
Parameters:
- `DATA_W`, 32, element width of one FMA result
- `ADDR_W`, 16, memory word-address width
- `FIFO_DEPTH`, 4, vector slots; power of two, ≥2

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  latch `cfg_base`/`cfg_count`, begin job
- `cfg_base`  in  ADDR_W  first destination word address
- `cfg_count`  in  16  vectors to retire; 0 means done immediately
- `in_valid`  in  1  result vector present (driven by controller `writeEn`)
- `in_data`  in  4·DATA_W  element 0 in bits [DATA_W-1:0]
- `in_ready`  out  1  slot free
- `mem_req`  out  1  write request
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  DATA_W  write data
- `mem_ack`  in  1  write accepted this cycle
- `busy`  out  1  job active
- `done`  out  1  one-cycle pulse, job complete
- `overflow`  out  1  sticky: push attempted while full

## Operation
- FSM states (`wb_state_t`): IDLE, POP, WRITE, FINISH.
- IDLE: on `start`, latch base and count, clear index and element counters, then go to POP. If `cfg_count`==0, go to FINISH instead.
- POP: if FIFO non-empty, pop the head into the 4-element holding register, set elem=0, and go to WRITE. Otherwise stay in POP.
- WRITE: drive `mem_req`=1 with `mem_addr` = base + {index,2'b00} + elem (mod 2^ADDR_W) and `mem_wdata` = element[elem].
  - On `mem_ack` with elem<3: elem++.
  - On `mem_ack` with elem==3: index++. If index+1==count, go to FINISH; otherwise go to POP.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- FIFO push condition: `in_valid` && `in_ready`. Pushes are accepted in any state, including IDLE; those vectors belong to the next job.
- `in_ready` = !full, computed from the registered occupancy. A pop in the same cycle does not free the slot until the next cycle.
- Push and pop in the same cycle: both happen and occupancy is unchanged.
- `in_valid` while full: data is dropped, `overflow` is set, and it stays set until reset.
- `start` while `busy` is ignored.
- Reset mid-job: FSM returns to IDLE, FIFO is emptied, all counters are cleared, and any outstanding request is abandoned.

## Timing
- Reset values:
  - `in_ready`=1
  - `mem_req`=0, `mem_addr`=0, `mem_wdata`=0
  - `busy`=0, `done`=0, `overflow`=0
- Registered outputs: `mem_req`, `mem_addr`, `mem_wdata`, `done`, `busy`.
- `mem_req`/`mem_addr`/`mem_wdata` are held stable until the cycle `mem_ack` is sampled high. The next element is presented in the following cycle, so back-to-back acks give 1 write per cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- Latency:
  - push to first `mem_req`: 2 cycles when the block is idle in POP
  - last ack to `done`: 2 cycles (WRITE→FINISH, then `done` registered)
- Minimum job time for N vectors with zero-wait ack: 1 + N·(1+4) + 1 cycles.

## Configuration
- `MATRIX_WB_STALL_CNT_EN`
  - Defined: adds output `stall_cycles` [15:0]. It counts cycles with `mem_req`=1 && `mem_ack`=0, clears on `start`, and saturates at 16'hFFFF.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `matrix_pkg`: `wb_state_t`, `VEC_LEN`=4, `ELEM_IDX_W`=2.
- Sub-module `wb_fifo`: parameterised by width and depth; synchronous; outputs full/empty/count.
- FSM, address generation, and counters live in the top module.

## Test plan
- Reset, then `start` with base=0x100, count=1, and push vector {4,3,2,1} with ack always high:
  - writes 0x100=1, 0x101=2, 0x102=3, 0x103=4
  - `done` pulses once; `busy` falls.
- count=3 with ack low for 2 of every 3 cycles:
  - 12 writes occur in address order 0x100–0x10B
  - address and data stay stable through every stall.
- Push 5 vectors with ack held low:
  - `in_ready` falls after the 4th push
  - the 5th push sets `overflow` and is dropped
  - after ack is released, exactly 4 vectors are written.
- base=0xFFFE, count=1:
  - addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- count=0:
  - `done` is asserted 1 cycle after `start`, with no `mem_req`.
- Assert `rst_n` low during the 2nd element write:
  - outputs return to reset values next cycle
  - after restart, writes begin again from element 0 of the new job.
